// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a pending-write scoreboard.
//
// Issue marks a destination register busy and writeback clears it. Reads
// report the stored data together with the register's busy flag, and issue
// logic uses that flag for hazard stalls. r0 is hard-wired to zero and is
// never busy.
//
// Ports
//   clk, reset_n            clock (rising edge); asynchronous active-low reset
//   rs_addr_i / rs_data_o   NRD combinational read ports, packed per port
//   rs_busy_o               per read port: the addressed register has a pending write
//   iss_en_i / iss_rd_i     issue: mark the destination register busy
//   wr0_*                   write port 0 (ALU)
//   wr1_*                   write port 1 (load/MMIO); wins when both ports hit the same register
//   busy_cnt_o              registered count of busy registers
//   wb_err_o                sticky flag: a register that was not busy got written
//
// Build option
//   REGFILE_BYPASS_EN  forward same-cycle write data, and the matching busy
//                      state, to read ports.

// One architectural register (r1..NREGS-1): data plus its busy bit.
module regfile_sb_cell #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr0_hit,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_hit,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            iss_hit,
  output logic [XLEN-1:0] q,
  output logic            busy,
  output logic            busy_nxt,
  output logic            err
);
  logic wr;

  assign wr       = wr0_hit | wr1_hit;
  // Issue wins over writeback (WAW re-issue keeps the register busy).
  assign busy_nxt = iss_hit | (busy & ~wr);
  // The check uses the busy state before the edge, so re-issue plus writeback
  // of a register that was already busy is legal.
  assign err      = wr & ~busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wr1_hit)      q <= wr1_data;
      else if (wr0_hit) q <= wr0_data;
      busy <= busy_nxt;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  output logic [AW:0]         busy_cnt_o,
  output logic                wb_err_o
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy_vec;
  logic [NREGS-1:0]           busy_nxt;
  logic [NREGS-1:0]           err_vec;
  logic [AW:0]                cnt_nxt;

  // r0 has no storage: it always reads zero, is never busy and never flags.
  assign regs[0]     = '0;
  assign busy_vec[0] = 1'b0;
  assign busy_nxt[0] = 1'b0;
  assign err_vec[0]  = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    regfile_sb_cell #(.XLEN(XLEN)) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr0_hit  (wr0_en_i && (wr0_addr_i == AW'(r))),
      .wr0_data (wr0_data_i),
      .wr1_hit  (wr1_en_i && (wr1_addr_i == AW'(r))),
      .wr1_data (wr1_data_i),
      .iss_hit  (iss_en_i && (iss_rd_i == AW'(r))),
      .q        (regs[r]),
      .busy     (busy_vec[r]),
      .busy_nxt (busy_nxt[r]),
      .err      (err_vec[r])
    );
  end

  // Count the post-edge busy vector, so the registered count matches busy_vec.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < NREGS; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt_o <= '0;
      wb_err_o   <= 1'b0;
    end else begin
      busy_cnt_o <= cnt_nxt;
      wb_err_o   <= wb_err_o | (|err_vec);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rs_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = wr0_en_i && (wr0_addr_i == addr) && (addr != '0);
    assign hit1 = wr1_en_i && (wr1_addr_i == addr) && (addr != '0);
    always_comb begin
      rs_data_o[k*XLEN +: XLEN] = regs[addr];
      rs_busy_o[k]              = busy_vec[addr];
      if (hit1 || hit0) begin
        rs_data_o[k*XLEN +: XLEN] = hit1 ? wr1_data_i : wr0_data_i;
        // The write retires this register, unless it is issued again in the
        // same cycle.
        rs_busy_o[k] = iss_en_i && (iss_rd_i == addr);
      end
    end
`else
    assign rs_data_o[k*XLEN +: XLEN] = regs[addr];
    assign rs_busy_o[k]              = busy_vec[addr];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic                iss_en_i;
  logic [AW-1:0]       iss_rd_i;
  logic                wr0_en_i, wr1_en_i;
  logic [AW-1:0]       wr0_addr_i, wr1_addr_i;
  logic [XLEN-1:0]     wr0_data_i, wr1_data_i;
  logic [AW:0]         busy_cnt_o;
  logic                wb_err_o;

  int n_cmp = 0;
  int n_err = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset_n(reset_n), .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
    .rs_busy_o(rs_busy_o), .iss_en_i(iss_en_i), .iss_rd_i(iss_rd_i),
    .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
    .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
    .busy_cnt_o(busy_cnt_o), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en_i = 1'b0; wr0_en_i = 1'b0; wr1_en_i = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rd0();
    return rs_data_o[0 +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rd1();
    return rs_data_o[XLEN +: XLEN];
  endfunction

  initial begin
    reset_n = 1'b0;
    rs_addr_i = '0; iss_rd_i = '0;
    wr0_addr_i = '0; wr1_addr_i = '0; wr0_data_i = '0; wr1_data_i = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rs_addr_i[0 +: AW] = 5'd5;
    #1;
    chk("rst_cnt", busy_cnt_o, 0);
    chk("rst_err", wb_err_o, 0);
    chk("rst_r5", rd0(), 0);
    reset_n = 1'b1;

    // 1: write r5, then reset again
    wr0_en_i = 1'b1; wr0_addr_i = 5'd5; wr0_data_i = 32'hDEAD_BEEF;
    step(); idle();
    chk("t1_r5", rd0(), 32'hDEAD_BEEF);
    chk("t1_err", wb_err_o, 1);
    reset_n = 1'b0;
    #2;
    chk("t1_rst_r5", rd0(), 0);
    chk("t1_rst_cnt", busy_cnt_o, 0);
    chk("t1_rst_err", wb_err_o, 0);
    reset_n = 1'b1;

    // 2: issue r3, then writeback via wp1
    rs_addr_i[0 +: AW] = 5'd3;
    iss_en_i = 1'b1; iss_rd_i = 5'd3;
    step(); idle();
    chk("t2_busy", rs_busy_o[0], 1);
    chk("t2_cnt1", busy_cnt_o, 1);
    wr1_en_i = 1'b1; wr1_addr_i = 5'd3; wr1_data_i = 32'h1234;
    step(); idle();
    chk("t2_busy0", rs_busy_o[0], 0);
    chk("t2_r3", rd0(), 32'h1234);
    chk("t2_cnt0", busy_cnt_o, 0);
    chk("t2_err", wb_err_o, 0);

    // 3: both ports write r7; write to r0 is ignored
    iss_en_i = 1'b1; iss_rd_i = 5'd7;
    step(); idle();
    rs_addr_i[0 +: AW] = 5'd7;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd7; wr0_data_i = 32'hAAAA;
    wr1_en_i = 1'b1; wr1_addr_i = 5'd7; wr1_data_i = 32'h5555;
    step(); idle();
    chk("t3_r7", rd0(), 32'h5555);
    chk("t3_cnt", busy_cnt_o, 0);
    rs_addr_i[AW +: AW] = 5'd0;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd0; wr0_data_i = 32'hFFFF_FFFF;
    step(); idle();
    chk("t3_r0", rd1(), 0);
    chk("t3_r0_busy", rs_busy_o[1], 0);
    chk("t3_err", wb_err_o, 0);

    // 4: re-issue plus write of a busy register, then write a non-busy register
    rs_addr_i[0 +: AW] = 5'd9;
    iss_en_i = 1'b1; iss_rd_i = 5'd9;
    step();
    wr0_en_i = 1'b1; wr0_addr_i = 5'd9; wr0_data_i = 32'h99;
    step(); idle();
    chk("t4_busy", rs_busy_o[0], 1);
    chk("t4_cnt", busy_cnt_o, 1);
    chk("t4_r9", rd0(), 32'h99);
    chk("t4_err0", wb_err_o, 0);
    wr0_en_i = 1'b1; wr0_addr_i = 5'd2; wr0_data_i = 32'h22;
    step(); idle();
    chk("t4_err1", wb_err_o, 1);
    wr1_en_i = 1'b1; wr1_addr_i = 5'd9; wr1_data_i = 32'h9;
    step(); idle();
    chk("t4_err_sticky", wb_err_o, 1);
    chk("t4_cnt0", busy_cnt_o, 0);

    // 5: fill the scoreboard, then drain it
    for (int i = 1; i < NREGS; i++) begin
      iss_en_i = 1'b1; iss_rd_i = AW'(i);
      step();
    end
    idle();
    chk("t5_full", busy_cnt_o, 31);
    rs_addr_i[0 +: AW] = 5'd31; rs_addr_i[AW +: AW] = 5'd0;
    #1;
    chk("t5_r31_busy", rs_busy_o[0], 1);
    chk("t5_r0_busy", rs_busy_o[1], 0);
    for (int i = 1; i < NREGS; i++) begin
      wr1_en_i = 1'b1; wr1_addr_i = AW'(i); wr1_data_i = XLEN'(i);
      step();
      if (i == 16) chk("t5_half", busy_cnt_o, 15);
    end
    idle();
    rs_addr_i[0 +: AW] = 5'd17;
    #1;
    chk("t5_empty", busy_cnt_o, 0);
    chk("t5_r17", rd0(), 17);

    // 6: same-cycle read of a register being written (r4 holds 4)
    rs_addr_i[0 +: AW] = 5'd4;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd4; wr0_data_i = 32'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t6_fwd", rd0(), 32'h77);
`else
    chk("t6_fwd", rd0(), 4);
`endif
    chk("t6_fwd_busy", rs_busy_o[0], 0);
    step(); idle();
    chk("t6_r4", rd0(), 32'h77);
    rs_addr_i[AW +: AW] = 5'd6;
    iss_en_i = 1'b1; iss_rd_i = 5'd6;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd6; wr0_data_i = 32'h66;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t6_iss_busy", rs_busy_o[1], 1);
`else
    chk("t6_iss_busy", rs_busy_o[1], 0);
`endif
    step(); idle();
    chk("t6_r6_busy", rs_busy_o[1], 1);
    chk("t6_r6", rd1(), 32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
